id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register for the MIPS datapath.
- Captures the register-file operands, the sign-extended immediate, PC+4, the register-address fields and the control bundles (WB/M/EX).
- Adds stall (hold), flush (bubble insert), a per-stage valid bit and in-stage load-use hazard detection.
- Adds saturating stall and bubble counters for performance debug.

Parameters:
- DATA_W, 32, width of the PC+4, rd1, rd2 and sign-extend paths.
- RADDR_W, 5, width of the register-address fields.
- ALUOP_W, 4, width of the ALU operation code.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- stall  in  1  external hold: all EX-side registers keep their value.
- flush  in  1  branch/jump redirect: load a bubble.
- cnt_clr  in  1  synchronous clear of both counters.
- add1, rd1, rd2, signext  in  DATA_W each  ID-stage datapath values.
- inst25_21, inst20_16, inst15_11  in  RADDR_W each  rs, rt and rd fields.
- RegWrite, MemtoReg, Branch, MemRead, MemWrite, Reg_Dst, Alu_Src  in  1 each  decoded control signals.
- Alu_Op  in  ALUOP_W  ALU operation code.
- WB  out  2  {MemtoReg, RegWrite}.
- M  out  3  {MemWrite, MemRead, Branch}.
- EX  out  ALUOP_W+2  {Alu_Src, Alu_Op, Reg_Dst}.
- ex_valid  out  1  the EX stage holds a real instruction.
- salidAdd1, salidard1, salidard2, salidasignext  out  DATA_W each  registered datapath values.
- salidainst25_21, salidainst20_16, salidainst15_11  out  RADDR_W each  registered register-address fields.
- hazard_stall  out  1  combinational load-use stall request to PC and IF/ID.
- stall_cnt, bubble_cnt  out  CNT_W each  performance counters.

Behaviour:
- All outputs are registered except hazard_stall. Latency is 1 cycle from ID inputs to outputs.
- Reset (rst_n=0 at a rising edge): every registered output becomes 0, including ex_valid and both counters.
- Load-use detect: hazard_stall = ex_valid & M[1] & (salidainst20_16 != 0) & id_valid & (salidainst20_16 == inst25_21 | salidainst20_16 == inst20_16).
- Per-edge priority: rst_n=0 > flush > stall > hazard_stall > normal load.
  - flush=1: WB, M, EX, ex_valid and all datapath/address outputs become 0 (bubble). flush wins over a simultaneous stall.
  - stall=1 (no flush): every output holds its value, including ex_valid.
  - hazard_stall=1 (no flush, no stall): insert a bubble, same as flush. The upstream holds the ID instruction via hazard_stall, so it re-enters on the next edge, when the hazard has cleared because ex_valid=0.
  - Normal load: capture all inputs with the packings above; ex_valid <= id_valid.
    - id_valid=0: WB, M and EX are forced to 0. Datapath values are still captured.
- A bubble never writes the register file or memory and never branches: WB, M and EX are all zero.
- Counters:
  - stall_cnt +1 on each edge with stall=1 and flush=0.
  - bubble_cnt +1 on each edge where flush=1 or a hazard bubble is inserted.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 zeroes both counters; the clear has priority over the increment in the same cycle.
  - rst_n=0 also clears both counters.
- Reset asserted mid-stall or mid-hazard: the outputs clear on that edge. hazard_stall then deasserts because ex_valid=0.
- Register $0 never raises a hazard.

Test Plan:
- Reset, then a normal load:
  - rst_n=0 for 2 cycles, then one load with rd1=32'hDEAD_BEEF, Alu_Op=4'b0010, RegWrite=1, id_valid=1.
  - Required: salidard1=32'hDEAD_BEEF, EX=6'b0_0010_0, WB=2'b01, ex_valid=1 one edge later.
- Stall:
  - Hold stall=1 for 3 cycles while the inputs change.
  - Required: the outputs keep their pre-stall values and stall_cnt=3.
- Flush with stall:
  - Assert flush=1 and stall=1 together.
  - Required: WB=M=EX=0, ex_valid=0, bubble_cnt increments by 1 and stall_cnt is unchanged.
- Load-use hazard:
  - EX holds lw with rt=5 (M=3'b010, ex_valid=1); ID has rs=5.
  - Required: hazard_stall=1, the next edge gives ex_valid=0, hazard_stall then drops, and the following edge loads the ID instruction.
- Load-use on $0:
  - lw with rt=0 and ID rs=0.
  - Required: hazard_stall=0.
- Counter saturation with CNT_W=2:
  - 5 stall cycles.
  - Required: stall_cnt=3.
  - Then cnt_clr=1 with stall=1 gives stall_cnt=0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the MIPS datapath.
// Holds the ID-stage operands, immediate, PC+4, register fields and the
// WB/M/EX control bundles for one cycle. It supports hold (stall), bubble
// insertion (flush or load-use hazard) and a per-stage valid bit, and it
// keeps saturating stall/bubble counters for performance debug.
module id_ex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 cnt_clr,
    input  logic [DATA_W-1:0]    add1,
    input  logic [DATA_W-1:0]    rd1,
    input  logic [DATA_W-1:0]    rd2,
    input  logic [DATA_W-1:0]    signext,
    input  logic [RADDR_W-1:0]   inst25_21,
    input  logic [RADDR_W-1:0]   inst20_16,
    input  logic [RADDR_W-1:0]   inst15_11,
    input  logic                 RegWrite,
    input  logic                 MemtoReg,
    input  logic                 Branch,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 Reg_Dst,
    input  logic                 Alu_Src,
    input  logic [ALUOP_W-1:0]   Alu_Op,
    output logic [1:0]           WB,
    output logic [2:0]           M,
    output logic [ALUOP_W+1:0]   EX,
    output logic                 ex_valid,
    output logic [DATA_W-1:0]    salidAdd1,
    output logic [DATA_W-1:0]    salidard1,
    output logic [DATA_W-1:0]    salidard2,
    output logic [DATA_W-1:0]    salidasignext,
    output logic [RADDR_W-1:0]   salidainst25_21,
    output logic [RADDR_W-1:0]   salidainst20_16,
    output logic [RADDR_W-1:0]   salidainst15_11,
    output logic                 hazard_stall,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]          r_wb;
    logic [2:0]          r_m;
    logic [ALUOP_W+1:0]  r_ex;
    logic                r_ex_valid;
    logic [DATA_W-1:0]   r_add1;
    logic [DATA_W-1:0]   r_rd1;
    logic [DATA_W-1:0]   r_rd2;
    logic [DATA_W-1:0]   r_signext;
    logic [RADDR_W-1:0]  r_rs;
    logic [RADDR_W-1:0]  r_rt;
    logic [RADDR_W-1:0]  r_rd;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_bubble_cnt;

    logic                w_hazard;
    logic                w_bubble;
    logic                w_stall_evt;

    // Load-use: a valid load in EX whose rt (never $0) is a source of the ID instruction.
    assign w_hazard = r_ex_valid & r_m[1] & (r_rt != '0) & id_valid &
                      ((r_rt == inst25_21) | (r_rt == inst20_16));

    // A hazard bubble only goes in when the stage is not being held.
    assign w_bubble    = flush | (~stall & w_hazard);
    assign w_stall_evt = stall & ~flush;

    // Pipeline capture: reset > bubble (flush/hazard) > hold > load.
    always_ff @(posedge clk) begin
        if (!rst_n || w_bubble) begin
            r_wb       <= '0;
            r_m        <= '0;
            r_ex       <= '0;
            r_ex_valid <= 1'b0;
            r_add1     <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_signext  <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
        end else if (!stall) begin
            // Control is squashed for an invalid slot; datapath is captured regardless.
            if (id_valid) begin
                r_wb <= {MemtoReg, RegWrite};
                r_m  <= {MemWrite, MemRead, Branch};
                r_ex <= {Alu_Src, Alu_Op, Reg_Dst};
            end else begin
                r_wb <= '0;
                r_m  <= '0;
                r_ex <= '0;
            end
            r_ex_valid <= id_valid;
            r_add1     <= add1;
            r_rd1      <= rd1;
            r_rd2      <= rd2;
            r_signext  <= signext;
            r_rs       <= inst25_21;
            r_rt       <= inst20_16;
            r_rd       <= inst15_11;
        end
    end

    // Saturating performance counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
        end
    end

    assign WB              = r_wb;
    assign M               = r_m;
    assign EX              = r_ex;
    assign ex_valid        = r_ex_valid;
    assign salidAdd1       = r_add1;
    assign salidard1       = r_rd1;
    assign salidard2       = r_rd2;
    assign salidasignext   = r_signext;
    assign salidainst25_21 = r_rs;
    assign salidainst20_16 = r_rt;
    assign salidainst15_11 = r_rd;
    assign hazard_stall    = w_hazard;
    assign stall_cnt       = r_stall_cnt;
    assign bubble_cnt      = r_bubble_cnt;

endmodule
